itch_msg_packer: RTL and testbench
==================================

# itch_msg_packer

Ingress packer that sits in front of the bid-side order-book `top`. It accepts the raw feed as a byte stream, assembles each message MSB-first into a 320-bit word, and queues completed words in a small FIFO. It presents the queue head on `ff_buffer` with `buffer_not_empty`, and pops one entry per rising edge of the book's `system_free`.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; power of two, 2..8.
- `MSG_BYTES`, 40: bytes per 320-bit word; fixed to 320/8.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: byte present on `in_data`.
- `in_data` in 8: feed byte; the first byte of a message is the type byte.
- `in_last` in 1: final byte of the message; qualified by `in_valid`.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `ff_buffer` out 320: FIFO head.
- `buffer_not_empty` out 1: FIFO count > 0.
- `system_free` in 1: book idle; its 0→1 edge pops the head.
- `overflow` out 1: one-cycle pulse when a message exceeds `MSG_BYTES`.
- `drop_count` out 16: count of discarded messages, saturating.

## Operation
- Assembly register `asm_q` is 320 bits. Byte k of a message (k = 0..39) lands in `asm_q[319-8k -: 8]`.
- A short message (`in_last` at k < 39) leaves the remaining low bytes zero.
- States:
  - IDLE: waits for the first accepted byte. Clears `asm_q`, writes byte 0, goes to COLLECT. If that byte also has `in_last`, goes directly to HOLD.
  - COLLECT: writes byte k and increments the 6-bit counter. `in_last` → HOLD. Accepting byte 40 without `in_last` pulses `overflow` and goes to DRAIN.
  - DRAIN: accepts and discards bytes until `in_last`, then returns to IDLE. Increments `drop_count`. No push.
  - HOLD: `in_ready`=0. Pushes `asm_q` when the FIFO is not full, or when a pop occurs in the same cycle, then returns to IDLE.
- `in_ready` = 1 in IDLE, COLLECT and DRAIN; 0 in HOLD.
- Pop condition: `system_free & ~sf_q & buffer_not_empty`, where `sf_q` is `system_free` registered.
  - A 0→1 edge while the FIFO is empty is ignored; nothing is remembered.
- Simultaneous push and pop: both happen, the count is unchanged, and the head advances.
- Read and write pointers wrap modulo `DEPTH`.
- `drop_count` saturates at 16'hFFFF.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after it; `ff_buffer`=0; `buffer_not_empty`=0; `overflow`=0; `drop_count`=0; `sf_q`=1, so a `system_free` already high at reset release does not pop; state IDLE; pointers and count 0.
- Latency from the last byte accepted at cycle N:
  - HOLD at N+1.
  - Push at the N+1 edge if the FIFO has space.
  - `buffer_not_empty` and `ff_buffer` valid at N+2.
- Pop: edge detected at cycle M; the new head (or `buffer_not_empty`=0) appears at M+1.
- Throughput: one message per (bytes + 1) cycles when the consumer keeps up.
- `ff_buffer` is stable while `buffer_not_empty`=1 and no pop occurs.
- Reset mid-message: the partial message is discarded and the FIFO is emptied.

## Configuration
- `ITCH_TYPE_FILTER_EN` defined: in HOLD, a message whose type byte is not 'A' (0x41), 'D' (0x44), 'E' (0x45) or 'S' (0x53) is dropped instead of pushed. `drop_count` increments and the state returns to IDLE in the same cycle.
- `ITCH_TYPE_FILTER_EN` undefined: every complete message is pushed; `drop_count` counts overflows only.

## Structure
- Shared package `itch_pkg` holds:
  - `MSG_BITS`=320 and `MSG_BYTES`=40.
  - Type-byte constants `MSG_ADD`, `MSG_DELETE`, `MSG_EXEC`, `MSG_SYSTEM`.
  - Packer state enum `pk_state_e`.
- Sub-module `itch_msg_fifo` holds the DEPTH×320 FIFO with push, pop, head and count.
- The top file holds the FSM, the assembler and the edge detector.

## Test plan
- Single message: send 40 bytes 53 78 56 … 00 with `in_last` on byte 39. `ff_buffer` must equal 320'h537856341278563412000103EA08000006000000004200000064000000000000005506000005 0000 and `buffer_not_empty` must be 1 two cycles after the last byte.
- Short message: 5 bytes 44 11 22 33 44 with `in_last`. Head must be 320'h4411223344 followed by 35 zero bytes.
- Backpressure: push 3 messages with `DEPTH`=2 and `system_free` held 0. `in_ready`=0 after the third; pulse `system_free` 0→1 → the first message pops and the third is pushed the same cycle, with count staying 2.
- Overflow: 45 bytes, last on byte 44. `overflow` pulses once at byte 40, `drop_count`=1, and nothing is pushed.
- Filter: message with type 0x58 and `ITCH_TYPE_FILTER_EN` defined → dropped, `drop_count`=1. With the macro undefined the same message is queued.
- Reset: assert `reset` after byte 20 with one entry queued. All outputs return to reset values and the next message assembles correctly.

Source files
------------

// File: rtl/itch_pkg.sv
// Purpose: shared constants, type-byte codes and packer state encoding for the ITCH ingress path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package itch_pkg;

    localparam int MSG_BITS  = 320;
    localparam int MSG_BYTES = MSG_BITS / 8;

    // Type bytes the order book consumes
    localparam logic [7:0] MSG_ADD    = 8'h41;  // 'A'
    localparam logic [7:0] MSG_DELETE = 8'h44;  // 'D'
    localparam logic [7:0] MSG_EXEC   = 8'h45;  // 'E'
    localparam logic [7:0] MSG_SYSTEM = 8'h53;  // 'S'

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_COLLECT,
        PK_DRAIN,
        PK_HOLD
    } pk_state_e;

    function automatic logic is_book_type(input logic [7:0] t);
        return (t == MSG_ADD) || (t == MSG_DELETE) || (t == MSG_EXEC) || (t == MSG_SYSTEM);
    endfunction

endpackage

// File: rtl/itch_msg_fifo.sv
// Purpose: DEPTH x WIDTH message queue; head is the oldest entry, zero when empty.
// Latency: push/pop take effect at the clock edge; head and count update the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), push/push_dat, pop, head_dat, count.
module itch_msg_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 320,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        // A full queue still accepts when the head leaves in the same cycle
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok) count_d = count_q + CW'(1);
        if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: rtl/itch_msg_packer.sv
// Purpose: assembles feed bytes MSB-first into 320-bit messages and queues them for the book.
// Latency: last byte at cycle N -> HOLD at N+1 -> head valid at N+2; pop edge at M -> new head at M+1.
// Backpressure: in_ready drops in HOLD until the queue has room (or pops in that cycle).
// Ports: byte stream in (in_valid/in_data/in_last/in_ready), queue head out (ff_buffer,
// buffer_not_empty), system_free pop strobe (rising edge), overflow pulse, drop_count.
// Option: ITCH_TYPE_FILTER_EN drops messages whose type byte is not A/D/E/S.
module itch_msg_packer #(
    parameter int DEPTH     = 2,
    parameter int MSG_BYTES = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [8*MSG_BYTES-1:0] ff_buffer,
    output logic                   buffer_not_empty,
    input  logic                   system_free,
    output logic                   overflow,
    output logic [15:0]            drop_count
);
    import itch_pkg::*;

    localparam int W  = 8 * MSG_BYTES;
    localparam int CW = $clog2(DEPTH) + 1;

    pk_state_e      state_q, state_d;
    logic [W-1:0]   asm_q, asm_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [15:0]    drop_q, drop_d;
    logic           overflow_q, overflow_d;
    logic           sf_q, sf_d;
    logic           accept, pop, push, drop_inc, type_ok, fifo_full;
    logic [CW-1:0]  fifo_count;

    assign in_ready         = !reset && (state_q != PK_HOLD);
    assign accept           = in_valid && in_ready;
    assign buffer_not_empty = (fifo_count != '0);
    assign fifo_full        = (fifo_count == CW'(DEPTH));
    assign pop              = system_free && !sf_q && buffer_not_empty;
    assign sf_d             = system_free;

`ifdef ITCH_TYPE_FILTER_EN
    assign type_ok = is_book_type(asm_q[W-1 -: 8]);
`else
    assign type_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        overflow_d = 1'b0;
        drop_inc   = 1'b0;
        push       = 1'b0;
        case (state_q)
            PK_IDLE: begin
                if (accept) begin
                    asm_d          = '0;
                    asm_d[W-1 -: 8] = in_data;
                    cnt_d          = 6'd1;
                    state_d        = in_last ? PK_HOLD : PK_COLLECT;
                end
            end
            PK_COLLECT: begin
                if (accept) begin
                    if (cnt_q == 6'(MSG_BYTES)) begin
                        // One byte too many: abandon the message, skip to its end
                        overflow_d = 1'b1;
                        drop_inc   = 1'b1;
                        state_d    = in_last ? PK_IDLE : PK_DRAIN;
                    end else begin
                        asm_d[W-1-8*int'(cnt_q) -: 8] = in_data;
                        cnt_d = cnt_q + 6'd1;
                        if (in_last) state_d = PK_HOLD;
                    end
                end
            end
            PK_DRAIN: begin
                if (accept && in_last) state_d = PK_IDLE;
            end
            PK_HOLD: begin
                if (!type_ok) begin
                    drop_inc = 1'b1;
                    state_d  = PK_IDLE;
                end else if (!fifo_full || pop) begin
                    push    = 1'b1;
                    state_d = PK_IDLE;
                end
            end
            default: state_d = PK_IDLE;
        endcase
        if (drop_inc && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PK_IDLE;
            asm_q      <= '0;
            cnt_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            // Treat system_free as already high so a level present at release is not an edge
            sf_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            sf_q       <= sf_d;
        end
    end

    itch_msg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (asm_q),
        .pop      (pop),
        .head_dat (ff_buffer),
        .count    (fifo_count)
    );

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_itch_msg_packer.sv
// Purpose: directed bench for itch_msg_packer with hand-computed message images.
// Latency: checks last-byte -> head at N+2 and pop edge -> new head at M+1.
// Backpressure: fills a DEPTH=2 queue and releases it with system_free edges.
module tb_itch_msg_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic [319:0] ff_buffer;
    logic         buffer_not_empty;
    logic         system_free;
    logic         overflow;
    logic [15:0]  drop_count;

    int checks   = 0;
    int failures = 0;
    int ovf_cnt  = 0;

    logic [7:0]   tx_q[$];
    logic [319:0] exp_v;

    localparam logic [319:0] SINGLE_MSG =
        320'h537856341278563412000103EA080000060000000042000000640000000000000055060000050000;

    itch_msg_packer #(.DEPTH(2), .MSG_BYTES(40)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .ff_buffer        (ff_buffer),
        .buffer_not_empty (buffer_not_empty),
        .system_free      (system_free),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Queue the first n bytes of m, MSB first
    task automatic load_msg(input logic [319:0] m, input int n);
        tx_q.delete();
        for (int k = 0; k < n; k++) tx_q.push_back(m[319-8*k -: 8]);
    endtask

    // Drive tx_q one byte per accepted cycle; returns at the negedge after the final byte
    task automatic send_q(input bit with_last);
        for (int k = 0; k < tx_q.size(); k++) begin
            int waitc = 0;
            while (!in_ready && waitc < 200) begin
                @(negedge clk);
                waitc++;
            end
            if (!in_ready) begin
                check_eq("in_ready_timeout", 320'(in_ready), 320'(1));
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_data  = tx_q[k];
            in_last  = with_last && (k == tx_q.size() - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop_pulse();
        system_free = 1'b1;
        @(negedge clk);
        system_free = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; system_free = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 320'(in_ready), 320'(0));
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ff_buffer", ff_buffer, 320'(0));
        check_eq("rst_not_empty", 320'(buffer_not_empty), 320'(0));
        check_eq("rst_overflow", 320'(overflow), 320'(0));
        check_eq("rst_drop", 320'(drop_count), 320'(0));
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 320'(in_ready), 320'(1));
        @(negedge clk);

        // Full 40-byte message
        load_msg(SINGLE_MSG, 40);
        send_q(1'b1);
        check_eq("single_n1_empty", 320'(buffer_not_empty), 320'(0));
        check_eq("single_hold_rdy", 320'(in_ready), 320'(0));
        @(negedge clk);
        check_eq("single_nempty", 320'(buffer_not_empty), 320'(1));
        check_eq("single_head", ff_buffer, SINGLE_MSG);
        pop_pulse();
        check_eq("single_popped", 320'(buffer_not_empty), 320'(0));
        check_eq("single_popped_head", ff_buffer, 320'(0));

        // Short message: low bytes stay zero
        exp_v = '0; exp_v[319:280] = 40'h4411223344;
        load_msg(exp_v, 5);
        send_q(1'b1);
        @(negedge clk);
        check_eq("short_head", ff_buffer, exp_v);
        pop_pulse();
        check_eq("short_popped", 320'(buffer_not_empty), 320'(0));

        // Edge while empty is not remembered
        system_free = 1'b1;
        @(negedge clk); @(negedge clk);
        exp_v = '0; exp_v[319:304] = 16'h4177;
        load_msg(exp_v, 2);
        send_q(1'b1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check_eq("empty_edge_kept", 320'(buffer_not_empty), 320'(1));
        check_eq("empty_edge_head", ff_buffer, exp_v);
        system_free = 1'b0;
        @(negedge clk);
        pop_pulse();
        check_eq("empty_edge_drain", 320'(buffer_not_empty), 320'(0));

        // Backpressure: three messages into two entries
        exp_v = '0; exp_v[319:304] = 16'h4101; load_msg(exp_v, 2); send_q(1'b1);
        exp_v = '0; exp_v[319:304] = 16'h4402; load_msg(exp_v, 2); send_q(1'b1);
        exp_v = '0; exp_v[319:304] = 16'h4503; load_msg(exp_v, 2); send_q(1'b1);
        @(negedge clk); @(negedge clk);
        check_eq("bp_in_ready", 320'(in_ready), 320'(0));
        exp_v = '0; exp_v[319:304] = 16'h4101;
        check_eq("bp_head_a", ff_buffer, exp_v);
        system_free = 1'b1;
        @(negedge clk);
        exp_v = '0; exp_v[319:304] = 16'h4402;
        check_eq("bp_head_b", ff_buffer, exp_v);
        check_eq("bp_released", 320'(in_ready), 320'(1));
        system_free = 1'b0;
        @(negedge clk);
        pop_pulse();
        exp_v = '0; exp_v[319:304] = 16'h4503;
        check_eq("bp_head_c", ff_buffer, exp_v);
        check_eq("bp_c_nempty", 320'(buffer_not_empty), 320'(1));
        pop_pulse();
        check_eq("bp_empty", 320'(buffer_not_empty), 320'(0));

        // Overflow: 45 bytes, last on byte 44
        tx_q.delete();
        tx_q.push_back(8'h41);
        for (int k = 1; k < 45; k++) tx_q.push_back(8'(k));
        send_q(1'b1);
        @(negedge clk); @(negedge clk);
        check_eq("ovf_pulses", 320'(ovf_cnt), 320'(1));
        check_eq("ovf_drop", 320'(drop_count), 320'(1));
        check_eq("ovf_no_push", 320'(buffer_not_empty), 320'(0));
        check_eq("ovf_idle_rdy", 320'(in_ready), 320'(1));

        // Type filter: 0x58 is not a book type
        exp_v = '0; exp_v[319:304] = 16'h58AA;
        load_msg(exp_v, 2);
        send_q(1'b1);
        @(negedge clk);
`ifdef ITCH_TYPE_FILTER_EN
        check_eq("filt_dropped", 320'(buffer_not_empty), 320'(0));
        check_eq("filt_drop_cnt", 320'(drop_count), 320'(2));
`else
        check_eq("filt_queued", 320'(buffer_not_empty), 320'(1));
        check_eq("filt_head", ff_buffer, exp_v);
        check_eq("filt_drop_cnt", 320'(drop_count), 320'(1));
        pop_pulse();
`endif

        // Reset mid-message with one entry queued
        exp_v = '0; exp_v[319:304] = 16'h5301;
        load_msg(exp_v, 2);
        send_q(1'b1);
        @(negedge clk);
        check_eq("mid_rst_queued", 320'(buffer_not_empty), 320'(1));
        load_msg(SINGLE_MSG, 21);
        send_q(1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_in_ready", 320'(in_ready), 320'(0));
        check_eq("mid_rst_nempty", 320'(buffer_not_empty), 320'(0));
        check_eq("mid_rst_head", ff_buffer, 320'(0));
        check_eq("mid_rst_drop", 320'(drop_count), 320'(0));
        check_eq("mid_rst_ovf", 320'(overflow), 320'(0));
        reset = 1'b0;
        #1;
        check_eq("mid_rst_rdy_after", 320'(in_ready), 320'(1));
        @(negedge clk);
        exp_v = '0; exp_v[319:280] = 40'h4411223344;
        load_msg(exp_v, 5);
        send_q(1'b1);
        @(negedge clk);
        check_eq("mid_rst_next_head", ff_buffer, exp_v);
        check_eq("mid_rst_next_nempty", 320'(buffer_not_empty), 320'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
